// File: rtl/veggie_gfx_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | veggie_gfx_pkg : shared frame-buffer geometry, types and blitter enums      |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
package veggie_gfx_pkg;

  localparam int H_RES  = 640;
  localparam int V_RES  = 480;
  localparam int ADDR_W = 19;
  localparam int PIX_W  = 8;

  localparam logic [PIX_W-1:0] TRANSPARENT_KEY = 8'hE3;

  typedef logic [ADDR_W-1:0] fb_addr_t;
  typedef logic [PIX_W-1:0]  pixel_t;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_CLEAR = 2'd1,
    OP_FILL  = 2'd2,
    OP_RSVD  = 2'd3
  } blit_op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_RASTER = 2'd2,
    ST_DONE   = 2'd3
  } blit_state_t;

endpackage
`default_nettype wire

// File: rtl/sprite_blitter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | sprite_blitter_if : draw-command handshake plus frame-buffer write port     |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
interface sprite_blitter_if;
  import veggie_gfx_pkg::*;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [9:0]  cmd_x;
  logic [9:0]  cmd_y;
  logic [9:0]  cmd_w;
  logic [9:0]  cmd_h;
  pixel_t      cmd_color;
  fb_addr_t    fb_wraddress;
  pixel_t      fb_data;
  logic        fb_wren;

  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    output cmd_ready, fb_wraddress, fb_data, fb_wren
  );

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    input  cmd_ready, fb_wraddress, fb_data, fb_wren
  );

endinterface
`default_nettype wire

// File: rtl/blit_clip.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | blit_clip : clips a draw rectangle to the screen and precomputes row base   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module blit_clip
  import veggie_gfx_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        is_clear,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic [9:0]  w,
  input  logic [9:0]  h,
  output logic [10:0] x0,
  output logic [10:0] y0,
  output logic [10:0] x1,
  output logic [10:0] y1,
  output fb_addr_t    row_base,
  output logic        empty
);

  logic [10:0] w_xs;
  logic [10:0] w_ys;

  // 11-bit sums cannot overflow for 10-bit operands
  assign w_xs = {1'b0, x} + {1'b0, w};
  assign w_ys = {1'b0, y} + {1'b0, h};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x0       <= '0;
      y0       <= '0;
      x1       <= '0;
      y1       <= '0;
      row_base <= '0;
      empty    <= 1'b0;
    end else if (load) begin
      if (is_clear) begin
        x0       <= '0;
        y0       <= '0;
        x1       <= 11'(H_RES);
        y1       <= 11'(V_RES);
        row_base <= '0;
        empty    <= 1'b0;
      end else begin
        x0       <= {1'b0, x};
        y0       <= {1'b0, y};
        x1       <= (w_xs > 11'(H_RES)) ? 11'(H_RES) : w_xs;
        y1       <= (w_ys > 11'(V_RES)) ? 11'(V_RES) : w_ys;
        row_base <= {y, 9'd0} + {2'd0, y, 7'd0};
        empty    <= (x >= 10'(H_RES)) || (y >= 10'(V_RES)) || (w == '0) || (h == '0);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sprite_blitter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | sprite_blitter : rasterises CLEAR/FILL commands into the 640x480 buffer     |
// | Option BLIT_TRANSPARENT_EN: FILL in TRANSPARENT_KEY walks but never writes. |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module sprite_blitter
  import veggie_gfx_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  sprite_blitter_if.slave bus,
  output logic            busy,
  output logic            done
);

  blit_state_t r_state, w_next;
  blit_op_t    w_op;
  logic        w_accept, w_draw, w_skip;
  logic        w_x_last, w_y_last;
  logic [10:0] r_cx, r_cy, w_cx, w_cy;
  fb_addr_t    r_rb, w_rb, r_addr, w_addr;
  pixel_t      r_color, r_data, w_data;
  logic        r_wren, w_wren, r_done, w_done;
  logic [10:0] w_x0, w_y0, w_x1, w_y1;
  fb_addr_t    w_row_base;
  logic        w_empty;

  assign w_op     = blit_op_t'(bus.cmd_op);
  assign w_accept = bus.cmd_valid && (r_state == ST_IDLE);
  assign w_draw   = (w_op == OP_CLEAR) || (w_op == OP_FILL);

  // The clipper doubles as the command latch: it only loads on accept.
  blit_clip u_clip (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (w_accept && w_draw),
    .is_clear (w_op == OP_CLEAR),
    .x        (bus.cmd_x),
    .y        (bus.cmd_y),
    .w        (bus.cmd_w),
    .h        (bus.cmd_h),
    .x0       (w_x0),
    .y0       (w_y0),
    .x1       (w_x1),
    .y1       (w_y1),
    .row_base (w_row_base),
    .empty    (w_empty)
  );

`ifdef BLIT_TRANSPARENT_EN
  logic r_skip;
  always_ff @(posedge clk) begin
    if (!reset_n)      r_skip <= 1'b0;
    else if (w_accept) r_skip <= (w_op == OP_FILL) && (bus.cmd_color == TRANSPARENT_KEY);
  end
  assign w_skip = r_skip;
`else
  assign w_skip = 1'b0;
`endif

  assign w_x_last = ((r_cx + 11'd1) == w_x1);
  assign w_y_last = ((r_cy + 11'd1) == w_y1);

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_cx   = r_cx;
    w_cy   = r_cy;
    w_rb   = r_rb;
    w_addr = r_addr;
    w_data = r_data;
    w_wren = 1'b0;
    w_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_draw) w_next = ST_SETUP;
          else        w_done = 1'b1;
        end
      end
      ST_SETUP: begin
        w_cx   = w_x0;
        w_cy   = w_y0;
        w_rb   = w_row_base;
        w_next = w_empty ? ST_DONE : ST_RASTER;
      end
      ST_RASTER: begin
        w_wren = !w_skip;
        w_addr = r_rb + {8'd0, r_cx};
        w_data = r_color;
        if (w_x_last) begin
          // Advance a row by addition so the loop carries no multiplier.
          w_cx = w_x0;
          w_cy = r_cy + 11'd1;
          w_rb = r_rb + fb_addr_t'(H_RES);
          if (w_y_last) w_next = ST_DONE;
        end else begin
          w_cx = r_cx + 11'd1;
        end
      end
      ST_DONE: begin
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cx    <= '0;
      r_cy    <= '0;
      r_rb    <= '0;
      r_color <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_wren  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_cx   <= w_cx;
      r_cy   <= w_cy;
      r_rb   <= w_rb;
      r_addr <= w_addr;
      r_data <= w_data;
      r_wren <= w_wren;
      r_done <= w_done;
      if (w_accept) r_color <= bus.cmd_color;
    end
  end

  assign bus.cmd_ready    = (r_state == ST_IDLE);
  assign bus.fb_wraddress = r_addr;
  assign bus.fb_data      = r_data;
  assign bus.fb_wren      = r_wren;
  assign busy             = (r_state != ST_IDLE);
  assign done             = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sprite_blitter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_sprite_blitter : scoreboard bench; build with BLIT_TRANSPARENT_EN to     |
// | expect magenta-keyed FILLs to be suppressed. Rev 1.0                        |
// +-----------------------------------------------------------------------------+
module tb_sprite_blitter;
  import veggie_gfx_pkg::*;

  logic clk;
  logic reset_n;
  logic busy;
  logic done;

  sprite_blitter_if bus();

  sprite_blitter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .busy    (busy),
    .done    (done)
  );

  typedef struct { int addr; int data; int cyc; } wr_t;
  typedef struct { int acc; int lat; } dn_t;

  wr_t wq[$];
  dn_t dq[$];
  int  cyc   = 0;
  int  n_vec = 0;
  int  n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached, cyc %0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cyc %0d",
               nm, act, act, exp, exp, cyc);
    end
  endtask

  // Monitor: every write and every done pulse is matched against the scoreboard
  always @(negedge clk) begin
    if (bus.fb_wren === 1'b1) begin
      chk("addr_in_range", int'(int'(bus.fb_wraddress) <= H_RES*V_RES-1), 1);
      if (wq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: addr %0d data 0x%0h, none expected (cyc %0d)",
                 bus.fb_wraddress, bus.fb_data, cyc);
      end else begin
        wr_t e;
        e = wq.pop_front();
        chk("wr_addr",  int'(bus.fb_wraddress), e.addr);
        chk("wr_data",  int'(bus.fb_data),      e.data);
        chk("wr_cycle", cyc,                    e.cyc);
      end
    end
    if (done === 1'b1) begin
      if (dq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: pulse with none expected (cyc %0d)", cyc);
      end else begin
        dn_t d;
        d = dq.pop_front();
        chk("done_latency", cyc - d.acc + 1, d.lat);
      end
    end
  end

  // Drive one command, wait for acceptance, then scramble the inputs and queue expectations
  task automatic issue(input logic [1:0] op, input int x, input int y, input int w,
                       input int h, input int color, input int max_wr,
                       input bit exp_done, output int acc);
    int  x0, y0, x1, y1, idx, pushed, budget;
    bit  skip, empty;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_x     = 10'(x);
    bus.cmd_y     = 10'(y);
    bus.cmd_w     = 10'(w);
    bus.cmd_h     = 10'(h);
    bus.cmd_color = 8'(color);
    budget = 0;
    while (bus.cmd_ready !== 1'b1 && budget < 400000) begin
      @(negedge clk);
      budget++;
    end
    if (bus.cmd_ready !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: cmd_ready got %b, expected 1 within budget", bus.cmd_ready);
    end
    @(negedge clk);
    acc = cyc;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd2;
    bus.cmd_x     = 10'h3FF;
    bus.cmd_y     = 10'h3FF;
    bus.cmd_w     = 10'h3FF;
    bus.cmd_h     = 10'h3FF;
    bus.cmd_color = 8'h55;
    chk("ready_after_accept", int'(bus.cmd_ready), (op == 2'd1 || op == 2'd2) ? 0 : 1);

    if (op == 2'd1) begin
      x0 = 0; y0 = 0; x1 = H_RES; y1 = V_RES;
    end else if (op == 2'd2) begin
      x0 = x; y0 = y;
      x1 = (x + w > H_RES) ? H_RES : x + w;
      y1 = (y + h > V_RES) ? V_RES : y + h;
    end else begin
      if (exp_done) dq.push_back('{acc: acc, lat: 1});
      return;
    end
`ifdef BLIT_TRANSPARENT_EN
    skip = (op == 2'd2) && (color == 'hE3);
`else
    skip = 1'b0;
`endif
    empty  = (x0 >= H_RES) || (y0 >= V_RES) || (x1 <= x0) || (y1 <= y0);
    idx    = 0;
    pushed = 0;
    if (!empty) begin
      for (int r = y0; r < y1; r++) begin
        for (int c = x0; c < x1; c++) begin
          if (!skip && (max_wr < 0 || pushed < max_wr)) begin
            wq.push_back('{addr: r*H_RES + c, data: color, cyc: acc + 2 + idx});
            pushed++;
          end
          idx++;
        end
      end
    end
    if (exp_done) dq.push_back('{acc: acc, lat: 3 + idx});
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((wq.size() != 0 || dq.size() != 0 || busy !== 1'b0) && b < 2000) begin
      @(negedge clk);
      b++;
    end
    chk("drain_pending_writes", wq.size(), 0);
    chk("drain_pending_done",   dq.size(), 0);
  endtask

  int acc, acc2;

  initial begin
    reset_n       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_x     = '0;
    bus.cmd_y     = '0;
    bus.cmd_w     = '0;
    bus.cmd_h     = '0;
    bus.cmd_color = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    chk("rst_cmd_ready",    int'(bus.cmd_ready),    1);
    chk("rst_fb_wren",      int'(bus.fb_wren),      0);
    chk("rst_fb_wraddress", int'(bus.fb_wraddress), 0);
    chk("rst_fb_data",      int'(bus.fb_data),      0);
    chk("rst_busy",         int'(busy),             0);
    chk("rst_done",         int'(done),             0);

    issue(2'd2, 10, 20, 3, 2, 'h1C, -1, 1'b1, acc);     // 6 writes, done at 9
    drain();
    issue(2'd2, 638, 479, 10, 10, 'h5A, -1, 1'b1, acc); // clipped to 2 pixels
    drain();
    issue(2'd2, 5, 5, 0, 4, 'h11, -1, 1'b1, acc);       // w=0
    drain();
    issue(2'd2, 700, 5, 4, 4, 'h22, -1, 1'b1, acc);     // off-screen x
    drain();
    issue(2'd0, 1, 1, 1, 1, 'h33, -1, 1'b1, acc);       // NOP
    drain();
    issue(2'd3, 1, 1, 1, 1, 'h44, -1, 1'b1, acc);       // reserved
    drain();
    issue(2'd2, 100, 50, 4, 4, 'hE3, -1, 1'b1, acc);    // magenta key
    drain();

    // Reset pulse after five writes of a 16-pixel fill
    issue(2'd2, 100, 100, 4, 4, 'h77, 5, 1'b0, acc);
    while (cyc < acc + 6) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("post_reset_wren",  int'(bus.fb_wren),   0);
    chk("post_reset_busy",  int'(busy),          0);
    chk("post_reset_ready", int'(bus.cmd_ready), 1);
    repeat (20) @(negedge clk);
    drain();

    issue(2'd2, 0, 0, 2, 2, 'hFF, -1, 1'b1, acc);
    drain();

    // Full-screen clear with a command queued behind it
    issue(2'd1, 123, 45, 6, 7, 'h00, -1, 1'b1, acc);
    issue(2'd2, 5, 5, 1, 1, 'hAA, -1, 1'b1, acc2);
    chk("b2b_accept_gap", acc2 - acc, 307203);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
